ipg_ingress: RTL
================

IPG_INGRESS -- requirements
Module: ipg_ingress

Interface
REQ-001 Parameter DATA_WIDTH, default 64, IPG word width.
REQ-002 Parameter ADR_WIDTH, default 40; src and dst are ADR_WIDTH/2 bits each.
REQ-003 Parameter MAX_MSG_WORDS, default 64, longest legal message in words, head and terminate included.
REQ-004 Port clk, input, 1, the single clock.
REQ-005 Port rst, input, 1, asynchronous active-low reset.
REQ-006 Port rx_ipg_en, input, 1, rx_ipg_data holds an IPG word this cycle.
REQ-007 Port rx_ipg_data, input, DATA_WIDTH, received IPG word.
REQ-008 Port ipg_en, output, 1, forwarded word valid; feeds ovport iv_ipg_en.
REQ-009 Port src and port dst, output, ADR_WIDTH/2 each, addresses of the message that owns the forwarded word.
REQ-010 Port rreq_valid, rresp_valid and wreq_valid, output, 1 each; type of the forwarded word; one-hot when ipg_en=1.
REQ-011 Port fwd_ipg_data, output, DATA_WIDTH, forwarded word, unmodified.
REQ-012 Port fwd_last, output, 1, forwarded word is a terminate word.
REQ-013 Port err_pulse, output, 1, one-cycle pulse for each protocol error.

Function
REQ-014 Word code field is data[7:0].
 - Head codes: 0x1A rreq, 0x1B rresp, 0x1C wreq.
 - Body codes: 0x2A, 0x2B, 0x2C.
 - Terminate codes: 0x3A, 0x3B, 0x3C.
REQ-015 Head word field layout: dst = data[27:8], src = data[47:28].
REQ-016 Each type has its own context (active, src, dst, word count), so messages of different types may interleave word-by-word on the link.
REQ-017 Head word, context inactive: latch src and dst, set active, set count=1, forward the word.
REQ-018 Body or terminate word, context active: forward the word with the context src and dst, then increment count.
REQ-019 Terminate word: also set fwd_last=1 and clear active.
REQ-020 All outputs are registered; latency from rx_ipg_en to ipg_en is exactly 1 cycle; no backpressure.
REQ-021 Head word while its context is already active:
 - Pulse err_pulse.
 - Restart the context with the new src and dst and count=1.
 - Forward the head word.
REQ-022 Body or terminate word while its context is inactive: drop it (ipg_en=0) and pulse err_pulse.
REQ-023 Unknown code: drop the word and pulse err_pulse; all contexts are unchanged.
REQ-024 A word that would make count exceed MAX_MSG_WORDS is dropped, its context is cleared, and err_pulse pulses.
 - The next word of that type is then an orphan; REQ-022 applies.
REQ-025 Count saturates and never wraps; a word arriving with count==MAX_MSG_WORDS is never forwarded.
REQ-026 rx_ipg_en=0: ipg_en=0, all valid flags 0, fwd_last=0, err_pulse=0; src, dst and fwd_ipg_data hold their last values.

Reset
REQ-027 Asserting rst immediately clears all of the following:
 - every output, to zero;
 - every context active bit;
 - every count.
REQ-028 A message in flight when reset asserts is abandoned; its later body and terminate words are orphans (REQ-022).
REQ-029 The first rising edge of clk after rst deasserts processes rx_ipg_en normally.

Configuration
REQ-030 Macro IPG_INGRESS_STATS_EN defined: add outputs msg_cnt[31:0] and err_cnt[31:0].
 - msg_cnt increments on each forwarded terminate word; err_cnt increments on each err_pulse.
 - Both counters reset to 0 and wrap at 2^32.
REQ-031 Macro not defined: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-032 Package ipg_pkg holds:
 - the word codes;
 - the field offsets;
 - the type enumeration (RREQ=0, RRESP=1, WREQ=2);
 - the per-type context struct.
REQ-033 Sub-module ipg_ctx holds one type's context and legality check; it is instantiated three times.

Verification
REQ-034 Head 0x1A (src=5, dst=2), then body 0x2A, then terminate 0x3A -> three cycles of ipg_en with rreq_valid=1 and src=5, dst=2; fwd_last=1 on the third word only; one cycle latency.
REQ-035 Interleave:
 - stimulus: head 0x1C (src=3), head 0x1A (src=7), body 0x2C, terminate 0x3A, terminate 0x3C;
 - response: the wreq words carry src=3, the rreq words carry src=7, valid flags correct on every word.
REQ-036 Terminate 0x3B with no head, then unknown code 0x55 -> no ipg_en; two err_pulse cycles; with stats compiled in, err_cnt=2.
REQ-037 MAX_MSG_WORDS=4, rreq head plus 4 bodies -> 4 words forwarded; 5th word dropped with err_pulse; a following 0x3A is dropped with err_pulse.
REQ-038 Assert rst mid-rresp message, release, send body 0x2B -> outputs zero during reset; body dropped with err_pulse.
REQ-039 Head 0x1A (src=1), then head 0x1A (src=9) without terminate -> err_pulse on the second head; the second head and the words after it carry src=9.

Source files
------------

// File: rtl/ipg_pkg.sv
// Shared definitions for the IPG ingress block: word codes, head field
// offsets, message type enumeration, per-type context record and decoder.
package ipg_pkg;

  // Code field sits in the low byte of every word
  localparam int unsigned CodeLsb   = 0;
  localparam int unsigned CodeW     = 8;
  // Head word address fields
  localparam int unsigned DstLsb    = 8;
  localparam int unsigned SrcLsb    = 28;
  localparam int unsigned AdrFieldW = 20;
  // Width of the per-context word counter
  localparam int unsigned CntW      = 16;

  localparam logic [7:0] CodeHeadRreq  = 8'h1A;
  localparam logic [7:0] CodeHeadRresp = 8'h1B;
  localparam logic [7:0] CodeHeadWreq  = 8'h1C;
  localparam logic [7:0] CodeBodyRreq  = 8'h2A;
  localparam logic [7:0] CodeBodyRresp = 8'h2B;
  localparam logic [7:0] CodeBodyWreq  = 8'h2C;
  localparam logic [7:0] CodeTermRreq  = 8'h3A;
  localparam logic [7:0] CodeTermRresp = 8'h3B;
  localparam logic [7:0] CodeTermWreq  = 8'h3C;

  typedef enum logic [1:0] {
    RREQ  = 2'd0,
    RRESP = 2'd1,
    WREQ  = 2'd2
  } ipg_type_e;

  typedef enum logic [1:0] {
    KindHead    = 2'd0,
    KindBody    = 2'd1,
    KindTerm    = 2'd2,
    KindUnknown = 2'd3
  } ipg_kind_e;

  typedef struct packed {
    ipg_kind_e kind;
    ipg_type_e typ;
  } ipg_dec_t;

  typedef struct packed {
    logic                 active;
    logic [AdrFieldW-1:0] src;
    logic [AdrFieldW-1:0] dst;
    logic [CntW-1:0]      count;
  } ipg_ctx_t;

  function automatic ipg_dec_t ipg_decode(input logic [7:0] code);
    ipg_dec_t d;
    d.kind = KindUnknown;
    d.typ  = RREQ;
    case (code)
      CodeHeadRreq:  begin d.kind = KindHead; d.typ = RREQ;  end
      CodeHeadRresp: begin d.kind = KindHead; d.typ = RRESP; end
      CodeHeadWreq:  begin d.kind = KindHead; d.typ = WREQ;  end
      CodeBodyRreq:  begin d.kind = KindBody; d.typ = RREQ;  end
      CodeBodyRresp: begin d.kind = KindBody; d.typ = RRESP; end
      CodeBodyWreq:  begin d.kind = KindBody; d.typ = WREQ;  end
      CodeTermRreq:  begin d.kind = KindTerm; d.typ = RREQ;  end
      CodeTermRresp: begin d.kind = KindTerm; d.typ = RRESP; end
      CodeTermWreq:  begin d.kind = KindTerm; d.typ = WREQ;  end
      default:       ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ipg_ctx.sv
// One message type's context: tracks active/src/dst/count and decides
// whether the current word of this type is forwarded or is an error.
module ipg_ctx
  import ipg_pkg::*;
#(
  parameter int unsigned MAX_MSG_WORDS = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 word_en_i,
  input  logic                 is_head_i,
  input  logic                 is_term_i,
  input  logic [AdrFieldW-1:0] head_src_i,
  input  logic [AdrFieldW-1:0] head_dst_i,
  output logic                 fwd_o,
  output logic                 err_o,
  output logic [AdrFieldW-1:0] fwd_src_o,
  output logic [AdrFieldW-1:0] fwd_dst_o
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_MSG_WORDS);

  ipg_ctx_t ctx_q, ctx_d;

  // Legality check and context update for a word of this type
  always_comb begin
    ctx_d     = ctx_q;
    fwd_o     = 1'b0;
    err_o     = 1'b0;
    fwd_src_o = ctx_q.src;
    fwd_dst_o = ctx_q.dst;
    if (word_en_i) begin
      if (is_head_i) begin
        // A head always (re)starts the context; a live context means the
        // previous message never terminated.
        err_o        = ctx_q.active;
        fwd_o        = 1'b1;
        ctx_d.active = 1'b1;
        ctx_d.src    = head_src_i;
        ctx_d.dst    = head_dst_i;
        ctx_d.count  = CntW'(1);
        fwd_src_o    = head_src_i;
        fwd_dst_o    = head_dst_i;
      end else if (!ctx_q.active) begin
        err_o = 1'b1;
      end else if (ctx_q.count >= MaxCnt) begin
        // Over-long message: drop and abandon so later words are orphans
        err_o = 1'b1;
        ctx_d = '0;
      end else begin
        fwd_o       = 1'b1;
        ctx_d.count = ctx_q.count + 1'b1;
        if (is_term_i) begin
          ctx_d.active = 1'b0;
        end
      end
    end
  end

  // Context register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctx_q <= '0;
    end else begin
      ctx_q <= ctx_d;
    end
  end

endmodule

// File: rtl/ipg_ingress.sv
// IPG ingress: decodes received words, tracks one context per message type
// and forwards legal words with their message addresses one cycle later.
// Optional statistics counters are compiled in with IPG_INGRESS_STATS_EN.
module ipg_ingress
  import ipg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADR_WIDTH     = 40,
  parameter int unsigned MAX_MSG_WORDS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_ipg_en,
  input  logic [DATA_WIDTH-1:0]  rx_ipg_data,
  output logic                   ipg_en,
  output logic [ADR_WIDTH/2-1:0] src,
  output logic [ADR_WIDTH/2-1:0] dst,
  output logic                   rreq_valid,
  output logic                   rresp_valid,
  output logic                   wreq_valid,
  output logic [DATA_WIDTH-1:0]  fwd_ipg_data,
  output logic                   fwd_last,
  output logic                   err_pulse
`ifdef IPG_INGRESS_STATS_EN
  ,
  output logic [31:0]            msg_cnt,
  output logic [31:0]            err_cnt
`endif
);

  localparam int unsigned HalfW = ADR_WIDTH / 2;

  ipg_dec_t             dec;
  logic                 unknown;
  logic [2:0]           word_en, fwd, err;
  logic [AdrFieldW-1:0] ctx_src [3];
  logic [AdrFieldW-1:0] ctx_dst [3];

  assign dec     = ipg_decode(rx_ipg_data[CodeLsb +: CodeW]);
  assign unknown = rx_ipg_en && (dec.kind == KindUnknown);

  for (genvar g = 0; g < 3; g++) begin : g_ctx
    assign word_en[g] = rx_ipg_en && (dec.kind != KindUnknown) && (int'(dec.typ) == g);

    ipg_ctx #(
      .MAX_MSG_WORDS(MAX_MSG_WORDS)
    ) u_ctx (
      .clk_i     (clk),
      .rst_ni    (rst),
      .word_en_i (word_en[g]),
      .is_head_i (dec.kind == KindHead),
      .is_term_i (dec.kind == KindTerm),
      .head_src_i(rx_ipg_data[SrcLsb +: AdrFieldW]),
      .head_dst_i(rx_ipg_data[DstLsb +: AdrFieldW]),
      .fwd_o     (fwd[g]),
      .err_o     (err[g]),
      .fwd_src_o (ctx_src[g]),
      .fwd_dst_o (ctx_dst[g])
    );
  end

  logic                  ipg_en_q, ipg_en_d;
  logic [HalfW-1:0]      src_q, src_d, dst_q, dst_d;
  logic [2:0]            valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [AdrFieldW-1:0]  sel_src, sel_dst;

  // Output next-state; address/data registers hold unless a word is forwarded
  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    for (int i = 0; i < 3; i++) begin
      if (fwd[i]) begin
        sel_src = sel_src | ctx_src[i];
        sel_dst = sel_dst | ctx_dst[i];
      end
    end
    ipg_en_d = |fwd;
    valid_d  = fwd;
    last_d   = (|fwd) && (dec.kind == KindTerm);
    err_d    = (|err) || unknown;
    src_d    = src_q;
    dst_d    = dst_q;
    data_d   = data_q;
    if (|fwd) begin
      src_d  = HalfW'(sel_src);
      dst_d  = HalfW'(sel_dst);
      data_d = rx_ipg_data;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ipg_en_q <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      valid_q  <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ipg_en_q <= ipg_en_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign ipg_en       = ipg_en_q;
  assign src          = src_q;
  assign dst          = dst_q;
  assign rreq_valid   = valid_q[RREQ];
  assign rresp_valid  = valid_q[RRESP];
  assign wreq_valid   = valid_q[WREQ];
  assign fwd_ipg_data = data_q;
  assign fwd_last     = last_q;
  assign err_pulse    = err_q;

`ifdef IPG_INGRESS_STATS_EN
  logic [31:0] msg_cnt_q, msg_cnt_d, err_cnt_q, err_cnt_d;

  // Counters advance together with the registered pulses they count
  always_comb begin
    msg_cnt_d = msg_cnt_q + {31'd0, last_d};
    err_cnt_d = err_cnt_q + {31'd0, err_d};
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      msg_cnt_q <= msg_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign msg_cnt = msg_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
